pipe_stage_reg: RTL and testbench

Parametrised pipeline-stage register that generalises the ID/EX-style stage latch with a valid/ready handshake, backpressure, flush-to-bubble and a stall counter. Upstream stage logic drives it; the next stage consumes it. Each beat carries a data field (operands, PC, immediates) and a control field (regwrite, memwrite, branch and similar bits). The control field is forced to zero whenever the stage holds a bubble, so an empty slot never commits architectural state.

---
 rtl/pipe_stage_reg.sv | 127 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Valid/ready pipeline-stage latch with flush-to-bubble, a bubble
//            control mask and a saturating stall counter. Defining
//            PIPE_STAGE_SKID_EN adds a skid entry and a registered in_ready.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_accept;
  logic              w_emit;

  assign w_accept = in_valid & in_ready;
  assign w_emit   = r_main_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  // in_ready depends only on state, breaking the out_ready -> in_ready path
  assign in_ready  = ~r_skid_valid;
  assign occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_ctrl  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_ctrl  <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_emit) begin
      if (r_skid_valid) begin
        r_main_data  <= r_skid_data;
        r_main_ctrl  <= r_skid_ctrl;
        r_skid_valid <= w_accept;
        if (w_accept) begin
          r_skid_data <= in_data;
          r_skid_ctrl <= in_ctrl;
        end
      end else if (w_accept) begin
        r_main_data <= in_data;
        r_main_ctrl <= in_ctrl;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      if (r_main_valid) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= in_data;
        r_skid_ctrl  <= in_ctrl;
      end else begin
        r_main_valid <= 1'b1;
        r_main_data  <= in_data;
        r_main_ctrl  <= in_ctrl;
      end
    end
  end
`else
  assign in_ready  = ~r_main_valid | out_ready;
  assign occupancy = {1'b0, r_main_valid};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_ctrl  <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
    end else if (w_accept) begin
      r_main_valid <= 1'b1;
      r_main_data  <= in_data;
      r_main_ctrl  <= in_ctrl;
    end else if (w_emit) begin
      r_main_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (stall_clr) begin
      r_stall_cnt <= '0;
    end else if (r_main_valid && !out_ready && (r_stall_cnt != c_CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // A bubble must never present a live control encoding downstream
  assign out_valid = r_main_valid;
  assign out_data  = r_main_data;
  assign out_ctrl  = r_main_valid ? r_main_ctrl : '0;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Self-checking bench for pipe_stage_reg against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int DATA_W = 96;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;
  logic              stall_clr;

  int n_chk = 0;
  int n_err = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: an ordered list of held beats
  typedef struct {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } beat_t;

  beat_t             q[$];
  int                m_cnt;
  logic [DATA_W-1:0] m_last;
  bit                m_known;

  function automatic bit m_in_ready();
`ifdef PIPE_STAGE_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || (out_ready == 1'b1);
`endif
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_cnt   = 0;
      m_last  = '0;
      m_known = 1'b1;
    end else begin
      bit    acc;
      bit    emit;
      beat_t b;
      acc  = in_valid && m_in_ready();
      emit = (q.size() > 0) && out_ready;
      if (stall_clr) m_cnt = 0;
      else if ((q.size() > 0) && !out_ready && (m_cnt < (1 << CNT_W) - 1)) m_cnt++;
      if (flush) begin
        q.delete();
        m_known = 1'b0;
      end else begin
        if (emit) void'(q.pop_front());
        if (acc) begin
          b.d = in_data;
          b.c = in_ctrl;
          q.push_back(b);
        end
        if (q.size() > 0) begin
          m_last  = q[0].d;
          m_known = 1'b1;
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("out_valid", out_valid, (q.size() > 0));
      chk("out_ctrl", out_ctrl, (q.size() > 0) ? q[0].c : '0);
      chk("occupancy", occupancy, q.size());
      chk("in_ready", in_ready, m_in_ready());
      chk("stall_cnt", stall_cnt, m_cnt);
      if (q.size() > 0) chk("out_data", out_data, q[0].d);
      else if (m_known) chk("out_data_bubble", out_data, m_last);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b1;
    stall_clr = 1'b1;
    cyc();
    flush     = 1'b0;
    stall_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    flush = 1'b0; out_ready = 1'b0; stall_clr = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_occupancy", occupancy, 2'd0);

    // Streaming 1..4, one-cycle latency, no bubbles
    idle();
    in_ctrl = 8'h01;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(i);
      cyc();
      chk("strm_valid", out_valid, 1'b1);
      chk("strm_data", out_data, i);
    end
    in_valid = 1'b0;
    cyc();
    chk("strm_end_valid", out_valid, 1'b0);

    // Bubble after a single beat
    idle();
    in_valid = 1'b1; in_data = 96'h5; in_ctrl = 8'hFF;
    cyc();
    in_valid = 1'b0;
    chk("bub_ctrl_ff", out_ctrl, 8'hFF);
    cyc();
    chk("bub_ctrl_0", out_ctrl, 8'h00);
    chk("bub_valid_0", out_valid, 1'b0);
    chk("bub_data_kept", out_data, 96'h5);

    // Backpressure holding 7, then 8 follows in order
    idle();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 96'd7; in_ctrl = 8'h11;
    cyc();
    chk("bp_data7", out_data, 96'd7);
    in_data = 96'd8; in_ctrl = 8'h22;
    cyc();
`ifdef PIPE_STAGE_SKID_EN
    in_valid = 1'b0;
    chk("bp_occ2", occupancy, 2'd2);
    chk("bp_in_ready0", in_ready, 1'b0);
`endif
    cyc();
    cyc();
    chk("bp_stall3", stall_cnt, 4'd3);
    chk("bp_hold7", out_data, 96'd7);
    chk("bp_hold_ctrl", out_ctrl, 8'h11);
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("bp_data8", out_data, 96'd8);
    chk("bp_ctrl8", out_ctrl, 8'h22);
    cyc();
    chk("bp_drained", out_valid, 1'b0);

    // Saturating stall counter and clear priority
    idle();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 96'd7; in_ctrl = 8'h11;
    cyc();
    in_valid = 1'b0;
    repeat (20) cyc();
    chk("cnt_sat", stall_cnt, 4'd15);
    stall_clr = 1'b1;
    cyc();
    stall_clr = 1'b0;
    chk("cnt_clr", stall_cnt, 4'd0);

    // Flush beats held and incoming
    idle();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 96'd7; in_ctrl = 8'h11;
    cyc();
`ifdef PIPE_STAGE_SKID_EN
    in_data = 96'd8; in_ctrl = 8'h22;
    cyc();
    chk("fl_occ2", occupancy, 2'd2);
`endif
    in_data = 96'd9; in_ctrl = 8'h33; flush = 1'b1; out_ready = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_ctrl", out_ctrl, 8'h00);
    chk("fl_occ0", occupancy, 2'd0);
    cyc();
    chk("fl_no_ghost", out_valid, 1'b0);

    // Randomized traffic against the model
    idle();
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 55);
      flush     = ($urandom_range(0, 99) < 4);
      stall_clr = ($urandom_range(0, 99) < 3);
      in_data   = {$urandom, $urandom, $urandom};
      in_ctrl   = CTRL_W'($urandom);
      cyc();
    end

    // Asynchronous reset mid-stream
    idle();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 96'h123; in_ctrl = 8'hA5;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("ar_pre_ctrl", out_ctrl, 8'hA5);
    chk("ar_pre_valid", out_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("ar_valid", out_valid, 1'b0);
    chk("ar_ctrl", out_ctrl, 8'h00);
    chk("ar_data", out_data, 96'h0);
    chk("ar_stall", stall_cnt, 4'd0);
    chk("ar_occ", occupancy, 2'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    out_ready = 1'b1;
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
